hex2ascii_tx: RTL
=================

HEX2ASCII_TX -- requirements
Module: hex2ascii_tx

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port din  input  16  value to print, 4 nibbles, MSB nibble first.
REQ-004 SHALL have port din_vld  input  1  one-cycle strobe qualifying din.
REQ-005 SHALL have port tx_rdy  input  1  downstream UART transmitter can accept a byte.
REQ-006 SHALL have port dout  output  8  ASCII character to transmit (registered).
REQ-007 SHALL have port dout_vld  output  1  one-cycle strobe qualifying dout (registered).
REQ-008 SHALL have port busy  output  1  high from capture until the last character is issued (registered).

Function
REQ-009 SHALL implement FSM states IDLE, SEND, GAP.
REQ-010 In IDLE with din_vld=1, SHALL latch din into a 16-bit holding register, clear the character counter cnt, set busy=1 and enter SEND at the next edge.
REQ-011 SHALL ignore din_vld while busy=1; the holding register SHALL NOT change.
REQ-012 In SEND with tx_rdy=1, SHALL drive dout=char(cnt) and dout_vld=1 for exactly one cycle (the cycle after the edge sampling tx_rdy), increment cnt and enter GAP.
REQ-013 In SEND with tx_rdy=0, SHALL hold state and cnt, with dout_vld=0.
REQ-014 GAP SHALL last exactly one cycle and ignore tx_rdy, then return to SEND, or to IDLE when the last character has been issued.
REQ-015 Nibble-to-ASCII mapping: 0-9 -> 8'h30-8'h39; A-F -> 8'h41-8'h46, uppercase only.
REQ-016 char(0..3) SHALL be nibbles din[15:12], din[11:8], din[7:4], din[3:0].
REQ-017 Latency: din_vld at cycle N with tx_rdy held 1 SHALL give first dout_vld at N+2; subsequent characters every 2 cycles.
REQ-018 busy SHALL fall in the same cycle the FSM re-enters IDLE; a din_vld in that cycle SHALL be accepted.
REQ-019 dout SHALL hold its last value when dout_vld=0.

Reset
REQ-020 On rst_n=0, SHALL immediately force state=IDLE, cnt=0, holding register=0, dout=8'h00, dout_vld=0, busy=0.
REQ-021 Reset mid-frame SHALL abandon the frame; no further characters are emitted after release until a new din_vld.

Configuration
REQ-022 With macro HEX2ASCII_TX_CRLF_EN defined, SHALL append 8'h0D then 8'h0A after the 4 hex characters (6 characters per frame, cnt 0..5), using the same SEND/GAP handshake.
REQ-023 Without HEX2ASCII_TX_CRLF_EN, each frame SHALL be exactly 4 characters (cnt 0..3).

Verification
REQ-024 din=16'h1A2F, din_vld 1 cycle, tx_rdy=1 -> dout_vld strobes with 8'h31, 8'h41, 8'h32, 8'h46 (plus 8'h0D, 8'h0A if CRLF_EN), first at N+2, spaced 2 cycles; busy low after last.
REQ-025 din=16'h09F0, tx_rdy low for 5 cycles after first char -> remaining chars 8'h39, 8'h46, 8'h30 delayed, none lost or duplicated, dout_vld never asserted while tx_rdy=0 in SEND.
REQ-026 din_vld with din=16'hFFFF while busy mid-frame of 16'h0000 -> output remains 8'h30 x4; 16'hFFFF never emitted.
REQ-027 rst_n pulsed low after second character of 16'hABCD -> dout=0, dout_vld=0, busy=0 immediately; no further strobes until next din_vld.
REQ-028 Back-to-back frames: second din_vld in cycle busy falls, din=16'h0001 -> accepted; chars 8'h30, 8'h30, 8'h30, 8'h31 follow.

Source files
------------

// File: rtl/hex2ascii_tx.sv
// Prints a captured 16-bit value as four uppercase ASCII hex characters, one per tx_rdy handshake.
// Define HEX2ASCII_TX_CRLF_EN to append CR, LF to every frame.
module hex2ascii_tx (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] din,
  input  logic        din_vld,
  input  logic        tx_rdy,
  output logic [7:0]  dout,
  output logic        dout_vld,
  output logic        busy
);

`ifdef HEX2ASCII_TX_CRLF_EN
  localparam logic [2:0] NumChars = 3'd6;
`else
  localparam logic [2:0] NumChars = 3'd4;
`endif

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  state_e      state_q, state_d;
  logic [15:0] hold_q, hold_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  dout_q, dout_d;
  logic        vld_q, vld_d;
  logic        busy_q, busy_d;
  logic [7:0]  cur_char;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
  endfunction

  always_comb begin
    cur_char = 8'h00;
    case (cnt_q)
      3'd0:    cur_char = hex_char(hold_q[15:12]);
      3'd1:    cur_char = hex_char(hold_q[11:8]);
      3'd2:    cur_char = hex_char(hold_q[7:4]);
      3'd3:    cur_char = hex_char(hold_q[3:0]);
`ifdef HEX2ASCII_TX_CRLF_EN
      3'd4:    cur_char = 8'h0D;
      3'd5:    cur_char = 8'h0A;
`endif
      default: cur_char = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    vld_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (din_vld) begin
          hold_d  = din;
          cnt_d   = 3'd0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (tx_rdy) begin
          dout_d  = cur_char;
          vld_d   = 1'b1;
          cnt_d   = cnt_q + 3'd1;
          state_d = StGap;
        end
      end
      StGap:   state_d = (cnt_q == NumChars) ? StIdle : StSend;
      default: state_d = StIdle;
    endcase
    // Registered busy tracks the next state so it drops together with the return to idle.
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      hold_q  <= 16'h0000;
      cnt_q   <= 3'd0;
      dout_q  <= 8'h00;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
    end
  end

  assign dout     = dout_q;
  assign dout_vld = vld_q;
  assign busy     = busy_q;

endmodule
